// File: rtl/karatsuba_pkg.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_pkg
// Description : Shared definitions for the Karatsuba arithmetic unit: default
//               operand widths, divider FSM state encoding and counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package karatsuba_pkg;

    // Dividend / quotient width; a divide takes this many iterations.
    localparam int DEF_DIVIDEND_W = 16;

    // Divisor / remainder width, matching the multiplier operand width.
    localparam int DEF_DIVISOR_W  = 8;

    // Iteration counter width for the default dividend width.
    localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W);

    // Divider control states; the encoding is fixed so debug taps stay stable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : karatsuba_pkg
`default_nettype wire

// File: rtl/karatsuba_div_step.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_div_step
// Description : One radix-2 restoring division step. Shifts the next dividend
//               bit into the partial remainder, compares against the divisor
//               and conditionally subtracts, producing one quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module karatsuba_div_step
    import karatsuba_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   i_pr,
    input  logic                 i_dbit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W:0]   o_pr,
    output logic                 o_qbit
);

    // The shifted value keeps one extra MSB so the compare is exact even
    // though, in normal operation, the incoming partial remainder is always
    // below the divisor and its top bit is zero.
    logic [DIVISOR_W+1:0] w_shifted;
    logic                 w_ge;
    logic [DIVISOR_W:0]   w_diff;

    assign w_shifted = {i_pr, i_dbit};
    assign w_ge      = (w_shifted >= {2'b00, i_divisor});

    // The true difference is below the divisor, so modular arithmetic on the
    // low DIVISOR_W+1 bits gives the exact result.
    assign w_diff    = w_shifted[DIVISOR_W:0] - {1'b0, i_divisor};

    assign o_pr      = w_ge ? w_diff : w_shifted[DIVISOR_W:0];
    assign o_qbit    = w_ge;

endmodule : karatsuba_div_step
`default_nettype wire

// File: rtl/karatsuba_div_8.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_div_8
// Description : Sequential radix-2 restoring divider, companion of the 8-bit
//               Karatsuba multiplier. Divides an unsigned dividend by an
//               unsigned divisor, one quotient bit per clock, with
//               valid/ready handshakes on operand and result sides.
//               Flags divide-by-zero and quotients too wide for a mult_8
//               operand.
// Revision    : 1.0 - initial release
// ============================================================================
module karatsuba_div_8
    import karatsuba_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero,
    output logic                  q_ovf
);

    localparam int                CNT_W  = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(DIVIDEND_W - 1);

    // ------------------------------------------------------------------
    // State, iteration and datapath registers
    // ------------------------------------------------------------------
    div_state_t            r_state;
    div_state_t            w_next_state;
    logic [CNT_W-1:0]      r_count;
    logic [DIVISOR_W:0]    r_pr;       // partial remainder
    logic [DIVIDEND_W-1:0] r_shift;    // dividend bits out at MSB, quotient bits in at LSB
    logic [DIVISOR_W-1:0]  r_divisor;

    // Result registers, updated only on entry to DONE
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_zero;
    logic                  r_q_ovf;

    // Step outputs and handshake decodes
    logic [DIVISOR_W:0]    w_pr_next;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] w_quot_final;
    logic                  w_accept;
    logic                  w_release;
    logic                  w_last_step;

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign w_accept     = in_valid && in_ready;
    assign w_release    = out_valid && out_ready;
    assign w_last_step  = (r_state == CALC) && (r_count == c_LAST);

    // Quotient as it stands once the current step's bit is shifted in.
    assign w_quot_final = {r_shift[DIVIDEND_W-2:0], w_qbit};

    assign quotient     = r_quotient;
    assign remainder    = r_remainder;
    assign div_zero     = r_div_zero;
    assign q_ovf        = r_q_ovf;

    // ------------------------------------------------------------------
    // Combinational shift / compare / subtract for the current iteration
    // ------------------------------------------------------------------
    karatsuba_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_pr      (r_pr),
        .i_dbit    (r_shift[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_pr      (w_pr_next),
        .o_qbit    (w_qbit)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: zero divisor skips the iteration phase entirely.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_count == c_LAST) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (w_release) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture and one restoring iteration per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_pr      <= '0;
            r_shift   <= '0;
            r_divisor <= '0;
        end else begin
            if (w_accept) begin
                r_count   <= '0;
                r_pr      <= '0;
                r_shift   <= dividend;
                r_divisor <= divisor;
            end else if (r_state == CALC) begin
                r_count   <= r_count + 1'b1;
                r_pr      <= w_pr_next;
                r_shift   <= w_quot_final;
            end
        end
    end

    // Result registers: loaded on the edge entering DONE, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_q_ovf     <= 1'b0;
        end else begin
            if (w_accept && (divisor == '0)) begin
                r_quotient  <= '1;
                r_remainder <= dividend[DIVISOR_W-1:0];
                r_div_zero  <= 1'b1;
                r_q_ovf     <= 1'b1;
            end else if (w_last_step) begin
                r_quotient  <= w_quot_final;
                r_remainder <= w_pr_next[DIVISOR_W-1:0];
                r_div_zero  <= 1'b0;
                r_q_ovf     <= |w_quot_final[DIVIDEND_W-1:DIVISOR_W];
            end
        end
    end

endmodule : karatsuba_div_8
`default_nettype wire

// File: tb/tb_karatsuba_div_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_karatsuba_div_8
// Description : Self-checking bench for karatsuba_div_8: directed cases with
//               literal expectations, randomized operands with backpressure,
//               mid-operation reset and multiply/divide round trips, all
//               checked against a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_karatsuba_div_8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        q_ovf;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t expq[$];
    logic prev_valid = 1'b0;

    karatsuba_div_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .q_ovf     (q_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero convention.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 16'hFFFF; e.r = a[7:0]; e.dz = 1'b1; e.ovf = 1'b1; e.lat = 1;
        end else begin
            e.q   = a / {8'd0, b};
            e.r   = 8'(a % {8'd0, b});
            e.dz  = 1'b0;
            e.ovf = (e.q > 16'd255);
            e.lat = 17;
        end
        e.acc = 0;
        return e;
    endfunction

    // Compare process: every cycle with out_valid high is checked against the
    // oldest outstanding model result; accepts are recorded as they happen.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            expq.delete();
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = expq[0];
                    chk("m_quotient", {16'd0, quotient}, {16'd0, e.q});
                    chk("m_remainder", {24'd0, remainder}, {24'd0, e.r});
                    chk("m_div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                    chk("m_q_ovf", {31'd0, q_ovf}, {31'd0, e.ovf});
                    if (!prev_valid) chk("m_latency", cyc - e.acc, e.lat);
                    if (out_ready) void'(expq.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                e = model(dividend, divisor);
                e.acc = cyc;
                expq.push_back(e);
            end
            prev_valid = out_valid;
        end
    end

    // Present operands and hold them until the accept edge has passed.
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        int n = 0;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges from the accept edge (counted as 1) to the edge raising out_valid.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic directed(input logic [15:0] a, input logic [7:0] b,
                            input logic [15:0] q, input logic [7:0] r,
                            input logic dz, input logic ovf, input int lat);
        int n;
        issue(a, b);
        wait_valid(n);
        chk("d_latency", n, lat);
        chk("d_quotient", {16'd0, quotient}, {16'd0, q});
        chk("d_remainder", {24'd0, remainder}, {24'd0, r});
        chk("d_div_zero", {31'd0, div_zero}, {31'd0, dz});
        chk("d_q_ovf", {31'd0, q_ovf}, {31'd0, ovf});
        take();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] rd;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {24'd0, remainder}, 32'd0);
        chk("rst_flags", {30'd0, div_zero, q_ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases with hand-computed results
        directed(16'd65025, 8'd255, 16'd255,   8'd0,    1'b0, 1'b0, 17);
        directed(16'd1000,  8'd7,   16'd142,   8'd6,    1'b0, 1'b0, 17);
        directed(16'h04D2,  8'd0,   16'hFFFF,  8'hD2,   1'b1, 1'b1, 1);
        directed(16'hFFFF,  8'd1,   16'hFFFF,  8'd0,    1'b0, 1'b1, 17);

        // Backpressure: result held while new operands toggle on the input
        issue(16'd5000, 8'd3);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            dividend = 16'($urandom);
            divisor  = 8'($urandom_range(1, 255));
            #3;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_quotient", {16'd0, quotient}, 32'd1666);
            chk("bp_remainder", {24'd0, remainder}, 32'd2);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        take();
        chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        directed(16'd200, 8'd7, 16'd28, 8'd4, 1'b0, 1'b0, 17);

        // Reset in the middle of an iteration (count == 8)
        issue(16'd1000, 8'd7);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_quotient", {16'd0, quotient}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        directed(16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 1'b0, 17);

        // Random operands with random result backpressure
        for (int i = 0; i < 300; i++) begin
            rd = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            issue(rd, rb);
            wait_valid(n);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            take();
        end

        // Round trip: (a*b)/b must give back a exactly
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(1, 255));
            rb = 8'($urandom_range(1, 255));
            issue(16'(ra * rb), rb);
            wait_valid(n);
            chk("rt_quotient", {16'd0, quotient}, {24'd0, ra});
            chk("rt_remainder", {24'd0, remainder}, 32'd0);
            take();
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", expq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule : tb_karatsuba_div_8
`default_nettype wire
